cpu_decode: RTL and testbench



---
 rtl/cpu_decode_if.sv | 36 +++
 rtl/cpu_decode.sv | 156 +++++++++++++++
 tb/tb_cpu_decode.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_decode_if.sv
// Stage 1a -> 2a decode bundle: fetch inputs, writeback port, kill, and the
// registered 2a outputs toward execute.
interface cpu_decode_if;
    logic [47:0] instruction_1a;
    logic [31:0] pc_1a;
    logic        kill_4a;
    logic        wb_en_5a;
    logic [3:0]  wb_reg_5a;
    logic [31:0] wb_data_5a;
    logic        stall_2a;
    logic        valid_2a;
    logic [31:0] pc_2a;
    logic [5:0]  alu_op_2a;
    logic [31:0] a_val_2a;
    logic [31:0] b_val_2a;
    logic [31:0] d_val_2a;
    logic [31:0] imm_2a;
    logic [3:0]  rd_2a;
    logic        we_2a;
    logic        load_2a;
    logic        store_2a;
    logic        branch_2a;
    logic        illegal_2a;

    modport slave (
        input  instruction_1a, pc_1a, kill_4a, wb_en_5a, wb_reg_5a, wb_data_5a,
        output stall_2a, valid_2a, pc_2a, alu_op_2a, a_val_2a, b_val_2a, d_val_2a,
               imm_2a, rd_2a, we_2a, load_2a, store_2a, branch_2a, illegal_2a
    );

    modport master (
        output instruction_1a, pc_1a, kill_4a, wb_en_5a, wb_reg_5a, wb_data_5a,
        input  stall_2a, valid_2a, pc_2a, alu_op_2a, a_val_2a, b_val_2a, d_val_2a,
               imm_2a, rd_2a, we_2a, load_2a, store_2a, branch_2a, illegal_2a
    );
endinterface

// File: rtl/cpu_decode.sv
// Pipeline stage 2: decode, 16x32 register file read with writeback bypass,
// load-use stall generation and kill flush into the 2a register.
module cpu_decode (
    input  logic        clk,
    input  logic        rst,
    cpu_decode_if.slave bus
);
    logic [31:0] r_rf [16];

    logic        r_valid, r_we, r_load, r_store, r_branch, r_illegal;
    logic [31:0] r_pc, r_a, r_b, r_d, r_imm;
    logic [5:0]  r_op;
    logic [3:0]  r_rd;

    logic [7:0]  w_op;
    logic [3:0]  w_rd, w_ra, w_rb;
    logic [31:0] w_imm;
    logic        w_use_ra, w_use_rb, w_use_rd, w_b_imm;
    logic        w_we, w_ld, w_st, w_br, w_il;
    logic [31:0] w_a, w_rbv, w_d;
    logic        w_hazard, w_stall;

    assign w_op  = bus.instruction_1a[47:40];
    assign w_rd  = bus.instruction_1a[39:36];
    assign w_ra  = bus.instruction_1a[35:32];
    assign w_imm = bus.instruction_1a[31:0];
    assign w_rb  = w_imm[3:0];

    always_comb begin
        w_use_ra = 1'b0;
        w_use_rb = 1'b0;
        w_use_rd = 1'b0;
        w_b_imm  = 1'b1;
        w_we     = 1'b0;
        w_ld     = 1'b0;
        w_st     = 1'b0;
        w_br     = 1'b0;
        w_il     = 1'b0;
        case (w_op[7:6])
            2'b00: begin
                if (w_op != 8'h00) begin
                    w_use_ra = 1'b1;
                    w_use_rb = 1'b1;
                    w_we     = 1'b1;
                    w_b_imm  = 1'b0;
                end
            end
            2'b01: begin
                if (w_op == 8'h40) begin
                    w_use_ra = 1'b1;
                    w_we     = 1'b1;
                    w_ld     = 1'b1;
                end else if (w_op == 8'h41) begin
                    w_use_ra = 1'b1;
                    w_use_rd = 1'b1;
                    w_st     = 1'b1;
                end else begin
                    w_il     = 1'b1;
                end
            end
            2'b10: begin
                w_use_ra = 1'b1;
                w_we     = 1'b1;
            end
            default: begin
                w_use_ra = 1'b1;
                w_use_rd = 1'b1;
                w_br     = 1'b1;
            end
        endcase
    end

    // r0 is hardwired zero; a same-cycle writeback wins over the stored value
    function automatic logic [31:0] f_read(input logic [3:0] idx, input logic [31:0] rf_val,
                                           input logic en, input logic [3:0] widx,
                                           input logic [31:0] wdata);
        if (idx == 4'd0)
            return 32'd0;
        else if (en && (widx == idx))
            return wdata;
        else
            return rf_val;
    endfunction

    assign w_a   = f_read(w_ra, r_rf[w_ra], bus.wb_en_5a, bus.wb_reg_5a, bus.wb_data_5a);
    assign w_rbv = f_read(w_rb, r_rf[w_rb], bus.wb_en_5a, bus.wb_reg_5a, bus.wb_data_5a);
    assign w_d   = f_read(w_rd, r_rf[w_rd], bus.wb_en_5a, bus.wb_reg_5a, bus.wb_data_5a);

    assign w_hazard = (w_use_ra && (w_ra == r_rd)) ||
                      (w_use_rb && (w_rb == r_rd)) ||
                      (w_use_rd && (w_rd == r_rd));
    // kill masks the stall so fetch sees the redirect
    assign w_stall  = r_valid && r_load && (r_rd != 4'd0) && w_hazard && !bus.kill_4a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_rf[i] <= 32'd0;
        end else if (bus.wb_en_5a && (bus.wb_reg_5a != 4'd0)) begin
            r_rf[bus.wb_reg_5a] <= bus.wb_data_5a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_load    <= 1'b0;
            r_store   <= 1'b0;
            r_branch  <= 1'b0;
            r_illegal <= 1'b0;
            r_pc      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_d       <= 32'd0;
            r_imm     <= 32'd0;
            r_op      <= 6'd0;
            r_rd      <= 4'd0;
        end else if (bus.kill_4a || w_stall) begin
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_load    <= 1'b0;
            r_store   <= 1'b0;
            r_branch  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid   <= (w_op != 8'h00);
            r_we      <= w_we && (w_rd != 4'd0);
            r_load    <= w_ld;
            r_store   <= w_st;
            r_branch  <= w_br;
            r_illegal <= w_il;
            r_pc      <= bus.pc_1a;
            r_a       <= w_a;
            r_b       <= w_b_imm ? w_imm : w_rbv;
            r_d       <= w_d;
            r_imm     <= w_imm;
            r_op      <= w_op[5:0];
            r_rd      <= w_rd;
        end
    end

    assign bus.stall_2a   = w_stall;
    assign bus.valid_2a   = r_valid;
    assign bus.pc_2a      = r_pc;
    assign bus.alu_op_2a  = r_op;
    assign bus.a_val_2a   = r_a;
    assign bus.b_val_2a   = r_b;
    assign bus.d_val_2a   = r_d;
    assign bus.imm_2a     = r_imm;
    assign bus.rd_2a      = r_rd;
    assign bus.we_2a      = r_we;
    assign bus.load_2a    = r_load;
    assign bus.store_2a   = r_store;
    assign bus.branch_2a  = r_branch;
    assign bus.illegal_2a = r_illegal;
endmodule

// File: tb/tb_cpu_decode.sv
// Scoreboard bench for cpu_decode: the driver queues the expected 2a bundle and
// stall per cycle, a negedge monitor pops and compares.
module tb_cpu_decode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_decode_if bus ();
    cpu_decode dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        stall;
        logic        valid;
        logic        dchk;
        logic [31:0] pc, a, b, d, imm;
        logic [5:0]  op;
        logic [3:0]  rd;
        logic        we, ld, st, br, il;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ev(input logic [31:0] pc, input logic [5:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] d, input logic [31:0] imm,
                                input logic [3:0] rd, input logic we, input logic ld,
                                input logic st, input logic br, input logic il);
        exp_t e;
        e.stall = 1'b0; e.valid = 1'b1; e.dchk = 1'b1;
        e.pc = pc; e.op = op; e.a = a; e.b = b; e.d = d; e.imm = imm; e.rd = rd;
        e.we = we; e.ld = ld; e.st = st; e.br = br; e.il = il;
        return e;
    endfunction

    function automatic exp_t zero_e(input logic dchk);
        exp_t e;
        e = ev(32'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e.valid = 1'b0;
        e.dchk  = dchk;
        return e;
    endfunction

    function automatic logic [47:0] ins(input logic [7:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [31:0] imm);
        return {op, rd, ra, imm};
    endfunction

    task automatic drv(input logic [47:0] in, input logic [31:0] pc, input logic kill,
                       input logic wben, input logic [3:0] wbr, input logic [31:0] wbd,
                       input logic stall, input exp_t nxt);
        exp_t e;
        @(posedge clk); #1;
        bus.instruction_1a = in;
        bus.pc_1a          = pc;
        bus.kill_4a        = kill;
        bus.wb_en_5a       = wben;
        bus.wb_reg_5a      = wbr;
        bus.wb_data_5a     = wbd;
        e = pend;
        e.stall = stall;
        q.push_back(e);
        pend = nxt;
    endtask

    task automatic chk_all_zero(input string tag);
        cmp({tag, "_stall"},  {31'd0, bus.stall_2a}, 32'd0);
        cmp({tag, "_valid"},  {31'd0, bus.valid_2a}, 32'd0);
        cmp({tag, "_pc"},     bus.pc_2a, 32'd0);
        cmp({tag, "_a"},      bus.a_val_2a, 32'd0);
        cmp({tag, "_b"},      bus.b_val_2a, 32'd0);
        cmp({tag, "_d"},      bus.d_val_2a, 32'd0);
        cmp({tag, "_imm"},    bus.imm_2a, 32'd0);
        cmp({tag, "_op_rd"},  {22'd0, bus.alu_op_2a, bus.rd_2a}, 32'd0);
        cmp({tag, "_flags"},  {27'd0, bus.we_2a, bus.load_2a, bus.store_2a,
                               bus.branch_2a, bus.illegal_2a}, 32'd0);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("stall", {31'd0, bus.stall_2a}, {31'd0, e.stall});
                cmp("valid", {31'd0, bus.valid_2a}, {31'd0, e.valid});
                cmp("flags", {27'd0, bus.we_2a, bus.load_2a, bus.store_2a, bus.branch_2a,
                              bus.illegal_2a}, {27'd0, e.we, e.ld, e.st, e.br, e.il});
                if (e.dchk) begin
                    cmp("pc",   bus.pc_2a, e.pc);
                    cmp("op",   {26'd0, bus.alu_op_2a}, {26'd0, e.op});
                    cmp("a",    bus.a_val_2a, e.a);
                    cmp("b",    bus.b_val_2a, e.b);
                    cmp("d",    bus.d_val_2a, e.d);
                    cmp("imm",  bus.imm_2a, e.imm);
                    cmp("rd",   {28'd0, bus.rd_2a}, {28'd0, e.rd});
                end
            end
        end
    end

    initial begin
        exp_t bub;
        bub = zero_e(1'b0);
        bus.instruction_1a = '0;
        bus.pc_1a = '0;
        bus.kill_4a = 1'b0;
        bus.wb_en_5a = 1'b0;
        bus.wb_reg_5a = '0;
        bus.wb_data_5a = '0;
        pend = zero_e(1'b1);
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // writes r1=5, r2=7 under NOPs
        drv(48'd0, 32'h0, 1'b0, 1'b1, 4'd1, 32'd5, 1'b0, bub);
        drv(48'd0, 32'h0, 1'b0, 1'b1, 4'd2, 32'd7, 1'b0, bub);
        drv(ins(8'h01, 4'd3, 4'd1, 32'd2), 32'h100, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h100, 6'h01, 32'd5, 32'd7, 32'd0, 32'd2, 4'd3, 1, 0, 0, 0, 0));
        // writeback bypass
        drv(ins(8'h01, 4'd6, 4'd4, 32'd0), 32'h104, 1'b0, 1'b1, 4'd4, 32'hDEADBEEF, 1'b0,
            ev(32'h104, 6'h01, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 4'd6, 1, 0, 0, 0, 0));
        // load-use: one stall cycle, one bubble, then the consumer
        drv(ins(8'h40, 4'd5, 4'd1, 32'h10), 32'h108, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h108, 6'h00, 32'd5, 32'h10, 32'd0, 32'h10, 4'd5, 1, 1, 0, 0, 0));
        drv(ins(8'h02, 4'd7, 4'd5, 32'd2), 32'h10C, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, bub);
        drv(ins(8'h02, 4'd7, 4'd5, 32'd2), 32'h10C, 1'b0, 1'b1, 4'd5, 32'h33, 1'b0,
            ev(32'h10C, 6'h02, 32'h33, 32'd7, 32'd0, 32'd2, 4'd7, 1, 0, 0, 0, 0));
        // load to r0 never stalls
        drv(ins(8'h40, 4'd0, 4'd2, 32'd4), 32'h110, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h110, 6'h00, 32'd7, 32'd4, 32'd0, 32'd4, 4'd0, 0, 1, 0, 0, 0));
        drv(ins(8'h03, 4'd8, 4'd0, 32'd0), 32'h114, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h114, 6'h03, 32'd0, 32'd0, 32'd0, 32'd0, 4'd8, 1, 0, 0, 0, 0));
        drv(ins(8'h41, 4'd4, 4'd1, 32'd8), 32'h118, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h118, 6'h01, 32'd5, 32'd8, 32'hDEADBEEF, 32'd8, 4'd4, 0, 0, 1, 0, 0));
        // kill flushes the store
        drv(ins(8'h85, 4'd1, 4'd1, 32'd0), 32'h0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, bub);
        drv(ins(8'h40, 4'd9, 4'd1, 32'd0), 32'h11C, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h11C, 6'h00, 32'd5, 32'd0, 32'd0, 32'd0, 4'd9, 1, 1, 0, 0, 0));
        // kill masks a live load-use hazard
        drv(ins(8'h01, 4'd2, 4'd9, 32'd0), 32'h0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, bub);
        drv(ins(8'h47, 4'd3, 4'd1, 32'd0), 32'h120, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h120, 6'h07, 32'd5, 32'd0, 32'd0, 32'd0, 4'd3, 0, 0, 0, 0, 1));
        drv(ins(8'h85, 4'd10, 4'd2, 32'h12345678), 32'h124, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h124, 6'h05, 32'd7, 32'h12345678, 32'd0, 32'h12345678, 4'd10, 1, 0, 0, 0, 0));
        drv(ins(8'hC1, 4'd4, 4'd1, 32'h40), 32'h128, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h128, 6'h01, 32'd5, 32'h40, 32'hDEADBEEF, 32'h40, 4'd4, 0, 0, 0, 1, 0));
        // r0 write is discarded
        drv(48'd0, 32'h0, 1'b0, 1'b1, 4'd0, 32'h55, 1'b0, bub);
        drv(ins(8'h01, 4'd11, 4'd0, 32'd0), 32'h12C, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h12C, 6'h01, 32'd0, 32'd0, 32'd0, 32'd0, 4'd11, 1, 0, 0, 0, 0));
        drv(ins(8'h40, 4'd12, 4'd2, 32'd0), 32'h130, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h130, 6'h00, 32'd7, 32'd0, 32'd0, 32'd0, 4'd12, 1, 1, 0, 0, 0));

        // reset asserted during a stall clears everything without an edge
        @(posedge clk); #1;
        bus.instruction_1a = ins(8'h01, 4'd1, 4'd0, 32'd12);
        bus.pc_1a = 32'h134;
        bus.kill_4a = 1'b0;
        bus.wb_en_5a = 1'b0;
        #1;
        cmp("stall_before_rst", {31'd0, bus.stall_2a}, 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        bus.instruction_1a = '0;
        bus.pc_1a = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend = zero_e(1'b1);

        // register file was cleared by reset
        drv(ins(8'h01, 4'd2, 4'd1, 32'd2), 32'h138, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0,
            ev(32'h138, 6'h01, 32'd0, 32'd0, 32'd0, 32'd2, 4'd2, 1, 0, 0, 0, 0));
        drv(48'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, bub);
        drv(48'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, bub);

        repeat (3) @(posedge clk);
        cmp("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
